alu_pipe: RTL

Parametrised, two-stage pipelined ALU with valid/ready handshakes on input and output and a registered status-flag vector. It generalises the team's 8-bit ALU to `WIDTH`-bit operands and adds backpressure, flags and illegal-opcode reporting. It sits between the driver-side operand source and the result consumer, and is exercised by the same driver/monitor bench structure as the existing ALU.

---
 rtl/alu_pipe.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage pipelined WIDTH-bit ALU with valid/ready handshakes
//
// Purpose:
//   S1 registers operands and opcode; S2 computes and registers result and
//   status flags. Each stage has its own valid bit and the pipe stalls from
//   the output back to the input, so ordering is preserved and nothing is
//   dropped or duplicated. Two ops can be in flight.
//
// Ports:
//   clock         in   single clock, rising edge
//   reset         in   synchronous, active-high
//   data_in       in   input valid for input_a / input_b / operator
//   input_a       in   operand A [WIDTH]
//   input_b       in   operand B [WIDTH]
//   operator      in   opcode [4]
//   in_ready      out  block can accept (independent of data_in)
//   result        out  registered result [WIDTH]
//   result_valid  out  result and flags are valid
//   result_ready  in   consumer accepts
//   flags         out  {illegal, overflow, negative, zero, carry}

module alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             data_in,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [3:0]       operator,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [4:0]       flags
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_EXT = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOT  = 4'd5,
    OP_SHL  = 4'd6,
    OP_SHR  = 4'd7,
    OP_INC  = 4'd8,
    OP_DEC  = 4'd9,
    OP_PASS = 4'd10,
    OP_CMP  = 4'd11
  } opcode_e;

  // Stage 1 state
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_a_q, s1_a_d;
  logic [WIDTH-1:0] s1_b_q, s1_b_d;
  logic [3:0]       s1_op_q, s1_op_d;

  // Stage 2 state
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [4:0]       flags_q, flags_d;

  // Handshake / stall chain
  logic s2_advance;
  logic s1_advance;

  always_comb begin
    s2_advance = !s2_valid_q || result_ready;
    s1_advance = !s1_valid_q || s2_advance;
  end

  // Held low during reset so the source cannot hand over an op that the
  // reset would immediately discard.
  assign in_ready     = s1_advance && !reset;
  assign result       = result_q;
  assign result_valid = s2_valid_q;
  assign flags        = flags_q;

  // Arithmetic with one extra bit to expose carry/borrow out of the top.
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic [WIDTH:0] inc_ext;
  logic [WIDTH:0] dec_ext;

  always_comb begin
    add_ext = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    sub_ext = {1'b0, s1_a_q} - {1'b0, s1_b_q};
    inc_ext = {1'b0, s1_a_q} + ONE_EXT;
    dec_ext = {1'b0, s1_a_q} - ONE_EXT;
  end

  // ALU evaluated on the S1 registers
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;
  logic             alu_ovf;
  logic             alu_illegal;
  logic [4:0]       alu_flags;

  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_ovf     = 1'b0;
    alu_illegal = 1'b0;
    case (s1_op_q)
      OP_ADD: begin
        alu_res   = add_ext[MSB:0];
        alu_carry = add_ext[WIDTH];
        // Same-sign operands producing a result of the other sign
        alu_ovf   = (s1_a_q[MSB] == s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_SUB: begin
        alu_res   = sub_ext[MSB:0];
        alu_carry = sub_ext[WIDTH];  // borrow: A < B unsigned
        // Opposite-sign operands producing a result whose sign differs from A
        alu_ovf   = (s1_a_q[MSB] != s1_b_q[MSB]) && (alu_res[MSB] != s1_a_q[MSB]);
      end
      OP_AND: alu_res = s1_a_q & s1_b_q;
      OP_OR:  alu_res = s1_a_q | s1_b_q;
      OP_XOR: alu_res = s1_a_q ^ s1_b_q;
      OP_NOT: alu_res = ~s1_a_q;
      OP_SHL: begin
        alu_res   = {s1_a_q[MSB-1:0], 1'b0};
        alu_carry = s1_a_q[MSB];
      end
      OP_SHR: begin
        alu_res   = {1'b0, s1_a_q[MSB:1]};
        alu_carry = s1_a_q[0];
      end
      OP_INC: begin
        alu_res   = inc_ext[MSB:0];
        alu_carry = inc_ext[WIDTH];
        alu_ovf   = !s1_a_q[MSB] && alu_res[MSB];
      end
      OP_DEC: begin
        alu_res   = dec_ext[MSB:0];
        alu_carry = dec_ext[WIDTH];  // borrow only when A == 0
        alu_ovf   = s1_a_q[MSB] && !alu_res[MSB];
      end
      OP_PASS: alu_res = s1_b_q;
      OP_CMP:  alu_res = {{(WIDTH-1){1'b0}}, (s1_a_q == s1_b_q)};
      default: alu_illegal = 1'b1;
    endcase
  end

  // Illegal ops report only the illegal bit even though the result is zero.
  always_comb begin
    alu_flags = {alu_illegal,
                 alu_ovf,
                 alu_res[MSB] && !alu_illegal,
                 (alu_res == '0) && !alu_illegal,
                 alu_carry};
  end

  // Next-state for both stages
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_op_d    = s1_op_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    flags_d    = flags_q;

    if (s1_advance) begin
      s1_valid_d = data_in;
      if (data_in) begin
        s1_a_d  = input_a;
        s1_b_d  = input_b;
        s1_op_d = operator;
      end
    end

    // Result and flags only change when a new op lands in S2, so they stay
    // stable both under backpressure and after the last op drains.
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        result_d = alu_res;
        flags_d  = alu_flags;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_op_q    <= '0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_op_q    <= s1_op_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
    end
  end

endmodule
